key_frame_assembler: RTL and testbench
======================================

KEY_FRAME_ASSEMBLER -- requirements
Module: key_frame_assembler

Interface
REQ-001 Parameter WIDTH, default 4: number of bits per assembled frame, legal range 2..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised cycles needed to accept a level change, legal range 1..65535.
REQ-003 Parameter MSB_FIRST, default 1: 1 = first accepted bit lands in data[WIDTH-1]; 0 = first bit lands in data[0].
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  raw, asynchronous push-button that arms a new frame.
REQ-007 key1  input  1  raw, asynchronous push-button that enters a 1 bit.
REQ-008 key0  input  1  raw, asynchronous push-button that enters a 0 bit.
REQ-009 data  output  WIDTH  assembled frame.
REQ-010 data_valid  output  1  one-cycle pulse when a frame completes.
REQ-011 busy  output  1  high while in COLLECT.
REQ-012 bit_count  output  $clog2(WIDTH+1)  bits accepted in the current frame.
REQ-013 conflict  output  1  one-cycle pulse when key1 and key0 events coincide.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchroniser, then a debouncer, then a rising-edge detector that produces a one-cycle event.
REQ-015 The debounced level SHALL change only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL reset the stability counter.
REQ-016 Event latency SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles from a clean raw rising edge to the event pulse.
REQ-017 The FSM SHALL have the states IDLE, COLLECT and DONE, and SHALL reset into IDLE.
REQ-018 IDLE: a start event SHALL clear data and bit_count and move to COLLECT; key events SHALL be ignored.
REQ-019 COLLECT: a single key1 or key0 event SHALL write 1 or 0 respectively into the next bit position and increment bit_count.
REQ-020 Bit position for accepted bit n (0-based) SHALL be WIDTH-1-n when MSB_FIRST=1, and n when MSB_FIRST=0.
REQ-021 When the WIDTH-th bit is accepted, the FSM SHALL go to DONE and data_valid SHALL pulse high in the cycle after the write, with the final data already stable.
REQ-022 DONE: data SHALL hold its value; key events SHALL be ignored; a start event SHALL behave as in IDLE.
REQ-023 A start event while in COLLECT SHALL abort the frame, clear data and bit_count, and remain in COLLECT.
REQ-024 A start event coinciding with a key event SHALL take priority, and the key event SHALL be discarded.
REQ-025 Coinciding key1 and key0 events in COLLECT SHALL write no bit, leave bit_count unchanged, and pulse conflict for one cycle.
REQ-026 bit_count SHALL never exceed WIDTH; in DONE it SHALL read WIDTH.

Reset
REQ-027 On rst, the synchronisers, debounced levels and stability counters SHALL clear to 0 asynchronously.
REQ-028 On rst, state SHALL be IDLE, data SHALL be 0, bit_count SHALL be 0, and data_valid, busy and conflict SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; no data_valid SHALL follow its release.
REQ-030 A button already held during reset release SHALL produce no event until it is released and pressed again.

Structure
REQ-031 The FSM state enumeration SHALL live in the shared project package.
REQ-032 The synchroniser, debouncer and edge detector SHALL be one sub-module, key_edge_sync, instantiated three times.
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 WIDTH=4, MSB_FIRST=1: start, then keys 1,0,1,1 -> data=4'b1011, one data_valid pulse, bit_count=4, busy low afterwards.
REQ-035 WIDTH=4, MSB_FIRST=0: start, then keys 1,0,1,1 -> data=4'b1101.
REQ-036 DEBOUNCE_CYCLES=4: key1 bouncing with 3-cycle pulses, then held for 10 cycles -> exactly one bit accepted; event at cycle 7 after the stable edge.
REQ-037 Start, keys 1,1, start, then keys 0,0,0,1 -> data=4'b0001; only one data_valid pulse.
REQ-038 key1 and key0 aligned in COLLECT -> one conflict pulse, bit_count unchanged; then keys 0,1,1,0 -> data=4'b0110.
REQ-039 rst asserted after 2 bits -> all outputs 0 immediately; no data_valid after release; keys before the next start are ignored.

Source files
------------

// File: rtl/key_frame_assembler_pkg.sv
// Shared types for the key frame assembler: FSM state encoding and synchroniser depth.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_frame_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } kfa_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/key_edge_sync.sv
// Raw button -> 2-flop synchroniser -> debouncer -> registered rising-edge event.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles from a clean raw rising edge to evt.
// Backpressure: none; evt is a single-cycle pulse that is never stalled.
module key_edge_sync
    import key_frame_assembler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);

    // Events stay masked until a level held through reset release has had time to settle.
    localparam int WARM = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int CW   = $clog2(WARM + 1);

    logic          sync1_d, sync1_q;
    logic          sync2_d, sync2_q;
    logic          lvl_d, lvl_q;
    logic          lvl_prev_d, lvl_prev_q;
    logic          evt_d, evt_q;
    logic [CW-1:0] stab_d, stab_q;
    logic [CW-1:0] warm_d, warm_q;

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        lvl_d      = lvl_q;
        lvl_prev_d = lvl_q;
        stab_d     = '0;
        warm_d     = warm_q;
        if (warm_q != CW'(WARM)) begin
            warm_d = warm_q + 1'b1;
        end
        if (sync2_q != lvl_q) begin
            if (stab_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
        evt_d = (warm_q == CW'(WARM)) && lvl_q && !lvl_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            evt_q      <= 1'b0;
            stab_q     <= '0;
            warm_q     <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            evt_q      <= evt_d;
            stab_q     <= stab_d;
            warm_q     <= warm_d;
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/key_frame_assembler.sv
// Assembles WIDTH-bit frames from debounced start/key1/key0 push-button events.
// Latency: bit lands 1 cycle after its key event; data_valid follows the last write by 1 cycle.
// Backpressure: none; data_valid and conflict are unconditional single-cycle pulses.
module key_frame_assembler
    import key_frame_assembler_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MSB_FIRST       = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       key1,
    input  logic                       key0,
    output logic [WIDTH-1:0]           data,
    output logic                       data_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       conflict
);

    localparam int               CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);

    logic start_evt, key1_evt, key0_evt;

    key_edge_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_sync (
        .clk(clk), .rst(rst), .raw(start), .evt(start_evt)
    );
    key_edge_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1_sync (
        .clk(clk), .rst(rst), .raw(key1), .evt(key1_evt)
    );
    key_edge_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0_sync (
        .clk(clk), .rst(rst), .raw(key0), .evt(key0_evt)
    );

    kfa_state_e       state_d, state_q;
    logic [WIDTH-1:0] data_d, data_q, bit_mask;
    logic [CW-1:0]    count_d, count_q;
    logic             fin_d, fin_q;
    logic             valid_d, valid_q;
    logic             busy_d, busy_q;
    logic             conflict_d, conflict_q;

    always_comb begin
        bit_mask   = (MSB_FIRST != 0) ? (MSB_ONE >> count_q) : (LSB_ONE << count_q);
        state_d    = state_q;
        data_d     = data_q;
        count_d    = count_q;
        fin_d      = 1'b0;
        conflict_d = 1'b0;
        // A start landing on the pulse cycle re-arms the frame, so the stale pulse is dropped.
        valid_d    = fin_q && !start_evt;
        if (start_evt) begin
            state_d = ST_COLLECT;
            data_d  = '0;
            count_d = '0;
        end else if (state_q == ST_COLLECT) begin
            if (key1_evt && key0_evt) begin
                conflict_d = 1'b1;
            end else if (key1_evt || key0_evt) begin
                data_d  = key1_evt ? (data_q | bit_mask) : (data_q & ~bit_mask);
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    fin_d   = 1'b1;
                end
            end
        end
        busy_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            count_q    <= '0;
            fin_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            count_q    <= count_d;
            fin_q      <= fin_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign bit_count  = count_q;
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_key_frame_assembler.sv
// Scoreboard bench: MSB-first and LSB-first instances share randomized button stimulus.
// A frame-level model queues expected frames/conflicts; negedge monitors pop and compare.
module tb_key_frame_assembler;

    localparam int W    = 4;
    localparam int DEB  = 4;
    localparam int HOLD = DEB + 6;
    localparam int CW   = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, start, key1, key0;
    logic [W-1:0]  data_m, data_l;
    logic          valid_m, valid_l, busy_m, busy_l, conf_m, conf_l;
    logic [CW-1:0] cnt_m, cnt_l;

    int checks = 0;
    int passes = 0;

    int exp_m[$];
    int exp_l[$];
    int cexp_m[$];
    int cexp_l[$];

    int mstate;   // 0 idle, 1 collecting, 2 done
    int mbits[$];
    int mdata_m, mdata_l, mcount;

    always #5 clk = ~clk;

    key_frame_assembler #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .start(start), .key1(key1), .key0(key0),
        .data(data_m), .data_valid(valid_m), .busy(busy_m), .bit_count(cnt_m), .conflict(conf_m)
    );

    key_frame_assembler #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .key1(key1), .key0(key0),
        .data(data_l), .data_valid(valid_l), .busy(busy_l), .bit_count(cnt_l), .conflict(conf_l)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        mstate  = 0;
        mbits.delete();
        mdata_m = 0;
        mdata_l = 0;
        mcount  = 0;
    endtask

    task automatic model_event(input bit s, input bit k1, input bit k0);
        if (s) begin
            model_reset();
            mstate = 1;
        end else if (mstate == 1) begin
            if (k1 && k0) begin
                cexp_m.push_back(mcount);
                cexp_l.push_back(mcount);
            end else if (k1 || k0) begin
                mbits.push_back(k1 ? 1 : 0);
                mcount  = mbits.size();
                mdata_m = 0;
                mdata_l = 0;
                foreach (mbits[n]) begin
                    mdata_m += mbits[n] << (W - 1 - n);
                    mdata_l += mbits[n] << n;
                end
                if (mcount == W) begin
                    mstate = 2;
                    exp_m.push_back(mdata_m);
                    exp_l.push_back(mdata_l);
                end
            end
        end
    endtask

    task automatic state_checks();
        check("busy_m", int'(busy_m), (mstate == 1) ? 1 : 0);
        check("busy_l", int'(busy_l), (mstate == 1) ? 1 : 0);
        check("bit_count_m", int'(cnt_m), mcount);
        check("bit_count_l", int'(cnt_l), mcount);
        check("data_m", int'(data_m), mdata_m);
        check("data_l", int'(data_l), mdata_l);
    endtask

    task automatic press(input bit s, input bit k1, input bit k0);
        @(negedge clk);
        start = s;
        key1  = k1;
        key0  = k0;
        model_event(s, k1, k0);
        repeat (HOLD) @(negedge clk);
        start = 1'b0;
        key1  = 1'b0;
        key0  = 1'b0;
        repeat (HOLD) @(negedge clk);
        state_checks();
    endtask

    // S=start, 1/0=key, C=both keys, T=start with key1
    task automatic run_seq(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s.getc(i))
                "S": press(1'b1, 1'b0, 1'b0);
                "1": press(1'b0, 1'b1, 1'b0);
                "0": press(1'b0, 1'b0, 1'b1);
                "C": press(1'b0, 1'b1, 1'b1);
                "T": press(1'b1, 1'b1, 1'b0);
                default: ;
            endcase
        end
    endtask

    task automatic reset_checks();
        check("rst_data_m", int'(data_m), 0);
        check("rst_data_l", int'(data_l), 0);
        check("rst_valid_m", int'(valid_m), 0);
        check("rst_valid_l", int'(valid_l), 0);
        check("rst_busy_m", int'(busy_m), 0);
        check("rst_busy_l", int'(busy_l), 0);
        check("rst_count_m", int'(cnt_m), 0);
        check("rst_count_l", int'(cnt_l), 0);
        check("rst_conflict_m", int'(conf_m), 0);
        check("rst_conflict_l", int'(conf_l), 0);
    endtask

    task automatic bounce_key1();
        int  lat;
        bit  seen;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            key1 = 1'b1;
            repeat (3) @(negedge clk);
            key1 = 1'b0;
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        key1 = 1'b1;
        model_event(1'b0, 1'b1, 1'b0);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (dut_m.u_key1_sync.evt) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("bounce_event_latency", lat, 2 + DEB + 1);
        repeat (HOLD) @(negedge clk);
        key1 = 1'b0;
        repeat (HOLD) @(negedge clk);
        state_checks();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_m) begin
                if (exp_m.size() == 0) check("valid_m_spurious", int'(valid_m), 0);
                else begin
                    check("frame_m", int'(data_m), exp_m.pop_front());
                    check("frame_count_m", int'(cnt_m), W);
                    check("frame_busy_m", int'(busy_m), 0);
                end
            end
            if (valid_l) begin
                if (exp_l.size() == 0) check("valid_l_spurious", int'(valid_l), 0);
                else begin
                    check("frame_l", int'(data_l), exp_l.pop_front());
                    check("frame_count_l", int'(cnt_l), W);
                end
            end
            if (conf_m) begin
                if (cexp_m.size() == 0) check("conflict_m_spurious", int'(conf_m), 0);
                else check("conflict_count_m", int'(cnt_m), cexp_m.pop_front());
            end
            if (conf_l) begin
                if (cexp_l.size() == 0) check("conflict_l_spurious", int'(conf_l), 0);
                else check("conflict_count_l", int'(cnt_l), cexp_l.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        key1  = 1'b0;
        key0  = 1'b0;
        model_reset();
        #1;
        reset_checks();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (HOLD) @(negedge clk);

        run_seq("1S1011");      // keys in IDLE ignored; 1011 frame
        run_seq("S11S0001");    // abort mid-frame, single pulse
        run_seq("SC0110");      // conflict then 0110
        run_seq("T0S");         // start+key: key discarded
        press(1'b1, 1'b0, 1'b0);
        bounce_key1();
        run_seq("101C1");

        for (int it = 0; it < 40; it++) begin
            int r;
            bit kb;
            r  = $urandom_range(0, 15);
            kb = 1'($urandom_range(0, 1));
            if (r == 0)      press(1'b1, 1'b0, 1'b0);
            else if (r == 1) press(1'b1, kb, !kb);
            else if (r == 2) press(1'b0, 1'b1, 1'b1);
            else             press(1'b0, kb, !kb);
        end

        // Reset mid-frame with start held across release.
        run_seq("S10");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        reset_checks();
        model_reset();
        start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (HOLD) @(negedge clk);
        state_checks();
        run_seq("1101");
        run_seq("S0111");

        repeat (20) @(negedge clk);
        check("frames_left_m", exp_m.size(), 0);
        check("frames_left_l", exp_l.size(), 0);
        check("conflicts_left_m", cexp_m.size(), 0);
        check("conflicts_left_l", cexp_l.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
